// File: rtl/sparse_sa_pkg.sv
// Shared configuration, FSM state type and element helpers for the
// sparse systolic-array scheduler. All widths derive from the constants here.
package sparse_sa_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int INDEX_SIZE = 3;
    localparam int N          = 2 ** INDEX_SIZE;
    localparam int MAX_NNZ    = 8;
    localparam int DRAIN_CYC  = 16;

    localparam int PTR_W  = $clog2(MAX_NNZ + 1);
    localparam int ELEM_W = INDEX_SIZE + DATA_WIDTH;
    localparam int T_STR  = MAX_NNZ + N;
    localparam int T_W    = $clog2(T_STR + 1);
    localparam int D_W    = $clog2(DRAIN_CYC + 1);
    localparam int RC_W   = 2 * INDEX_SIZE;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STREAM,
        DRAIN,
        READOUT
    } state_t;

    function automatic logic [ELEM_W-1:0] elem_pack(
        input logic [INDEX_SIZE-1:0] idx,
        input logic [DATA_WIDTH-1:0] val
    );
        return {idx, val};
    endfunction

    function automatic logic [INDEX_SIZE-1:0] elem_idx(input logic [ELEM_W-1:0] e);
        return e[ELEM_W-1:DATA_WIDTH];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] elem_val(input logic [ELEM_W-1:0] e);
        return e[DATA_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/sparse_sa_scheduler_if.sv
// Result readout handshake (valid/ready) with row/column tags.
// master: scheduler drives valid/data/row/col; slave: consumer drives ready.
interface sparse_sa_scheduler_if;
    import sparse_sa_pkg::*;

    logic                  res_valid;
    logic                  res_ready;
    logic [DATA_WIDTH-1:0] res_data;
    logic [INDEX_SIZE-1:0] res_row;
    logic [INDEX_SIZE-1:0] res_col;

    modport master (
        output res_valid, res_data, res_row, res_col,
        input  res_ready
    );

    modport slave (
        input  res_valid, res_data, res_row, res_col,
        output res_ready
    );

endinterface

// File: rtl/sparse_skew_lane.sv
// One edge lane: latches its nnz count, issues skewed read pointers and muxes
// returned {index,value} elements or zero sentinels onto the array edge.
// Ports: clk/rst_n, load/run/flush controls, stream time t, nnz_in,
//   rd_ptr/rd_data buffer port, edge_val/edge_idx, ovf and zero_err flags.
module sparse_skew_lane
    import sparse_sa_pkg::*;
#(
    parameter int LANE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  run,
    input  logic                  flush,
    input  logic [T_W-1:0]        t,
    input  logic [PTR_W-1:0]      nnz_in,
    input  logic [ELEM_W-1:0]     rd_data,
    output logic [PTR_W-1:0]      rd_ptr,
    output logic [DATA_WIDTH-1:0] edge_val,
    output logic [INDEX_SIZE-1:0] edge_idx,
    output logic                  ovf,
    output logic                  zero_err
);

    localparam logic [PTR_W-1:0] CAP  = PTR_W'(MAX_NNZ);
    localparam logic [T_W:0]     SKEW = (T_W + 1)'(LANE);

    logic [PTR_W-1:0] nnz;
    logic [T_W:0]     off;
    logic             issue;
    logic             mask_d;

    assign ovf = nnz_in > CAP;

    // Extra top bit is the borrow: set while t is still before this lane's slot.
    assign off   = {1'b0, t} - SKEW;
    assign issue = run && !off[T_W] && (off[T_W-1:0] < T_W'(nnz));
    assign rd_ptr = issue ? off[PTR_W-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nnz <= '0;
        end else if (flush) begin
            nnz <= '0;
        end else if (load) begin
            nnz <= ovf ? CAP : nnz_in;
        end
    end

    // Buffer data lags the pointer by one cycle, so the mask follows it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_d <= 1'b0;
        end else if (flush) begin
            mask_d <= 1'b0;
        end else begin
            mask_d <= issue;
        end
    end

    assign edge_val = mask_d ? elem_val(rd_data) : '0;
    assign edge_idx = mask_d ? elem_idx(rd_data) : '0;
    assign zero_err = mask_d && (elem_val(rd_data) == '0);

endmodule

// File: rtl/sparse_sa_scheduler.sv
// Sequences one sparse matmul pass: LOAD nnz, STREAM skewed lists, DRAIN,
// then READOUT of N*N results over the res handshake interface.
// Ports: clk/rst_n, start/abort, busy/done/cfg_err status, A/B nnz and
//   buffer read ports, array edge outputs, arr_result input, res (master).
module sparse_sa_scheduler
    import sparse_sa_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    output logic                         busy,
    output logic                         done,
    output logic                         cfg_err,
    input  logic [N*PTR_W-1:0]           a_nnz,
    input  logic [N*PTR_W-1:0]           b_nnz,
    output logic [N*PTR_W-1:0]           a_rd_ptr,
    output logic [N*PTR_W-1:0]           b_rd_ptr,
    input  logic [N*ELEM_W-1:0]          a_rd_data,
    input  logic [N*ELEM_W-1:0]          b_rd_data,
    output logic [N*DATA_WIDTH-1:0]      arr_left,
    output logic [N*INDEX_SIZE-1:0]      arr_left_idx,
    output logic [N*DATA_WIDTH-1:0]      arr_up,
    output logic [N*INDEX_SIZE-1:0]      arr_up_idx,
    input  logic [N*N*DATA_WIDTH-1:0]    arr_result,
    sparse_sa_scheduler_if.master        res
);

    state_t           state;
    state_t           state_n;
    logic [T_W-1:0]   t;
    logic [D_W-1:0]   dcnt;
    logic [RC_W-1:0]  rc;
    logic             res_hs;
    logic             last;
    logic             lane_load;
    logic             lane_run;
    logic [N-1:0]     a_ovf;
    logic [N-1:0]     b_ovf;
    logic [N-1:0]     a_zero;
    logic [N-1:0]     b_zero;
    logic [DATA_WIDTH-1:0] res_mem [N*N];

    assign lane_load = (state == LOAD) && !abort;
    assign lane_run  = (state == STREAM);

    for (genvar k = 0; k < N; k++) begin : g_lane
        sparse_skew_lane #(.LANE(k)) u_a (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (lane_load),
            .run      (lane_run),
            .flush    (abort),
            .t        (t),
            .nnz_in   (a_nnz[k*PTR_W +: PTR_W]),
            .rd_data  (a_rd_data[k*ELEM_W +: ELEM_W]),
            .rd_ptr   (a_rd_ptr[k*PTR_W +: PTR_W]),
            .edge_val (arr_left[k*DATA_WIDTH +: DATA_WIDTH]),
            .edge_idx (arr_left_idx[k*INDEX_SIZE +: INDEX_SIZE]),
            .ovf      (a_ovf[k]),
            .zero_err (a_zero[k])
        );

        sparse_skew_lane #(.LANE(k)) u_b (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (lane_load),
            .run      (lane_run),
            .flush    (abort),
            .t        (t),
            .nnz_in   (b_nnz[k*PTR_W +: PTR_W]),
            .rd_data  (b_rd_data[k*ELEM_W +: ELEM_W]),
            .rd_ptr   (b_rd_ptr[k*PTR_W +: PTR_W]),
            .edge_val (arr_up[k*DATA_WIDTH +: DATA_WIDTH]),
            .edge_idx (arr_up_idx[k*INDEX_SIZE +: INDEX_SIZE]),
            .ovf      (b_ovf[k]),
            .zero_err (b_zero[k])
        );
    end

    assign res_hs = res.res_valid && res.res_ready;
    assign last   = (rc == '1);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = LOAD;
            LOAD:    state_n = STREAM;
            STREAM:  if (t == T_W'(T_STR - 1)) state_n = DRAIN;
            DRAIN:   if (dcnt == D_W'(DRAIN_CYC - 1)) state_n = READOUT;
            READOUT: if (res_hs && last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (abort) state_n = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t <= '0;
        end else if (state == STREAM && !abort) begin
            t <= t + 1'b1;
        end else begin
            t <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt <= '0;
        end else if (state == DRAIN && !abort) begin
            dcnt <= dcnt + 1'b1;
        end else begin
            dcnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rc <= '0;
        end else if (state == READOUT && !abort) begin
            if (res_hs) rc <= rc + 1'b1;
        end else begin
            rc <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done <= 1'b0;
        else        done <= !abort && (state == READOUT) && res_hs && last;
    end

    // LOAD overwrites the flag (clearing the previous pass); zero
    // elements seen during streaming set it afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err <= 1'b0;
        end else if (lane_load) begin
            cfg_err <= |{a_ovf, b_ovf};
        end else if (|{a_zero, b_zero}) begin
            cfg_err <= 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < N * N; i++) begin
            res_mem[i] = arr_result[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign busy          = (state != IDLE);
    assign res.res_valid = (state == READOUT);
    assign res.res_data  = res_mem[rc];
    assign res.res_row   = rc[RC_W-1:INDEX_SIZE];
    assign res.res_col   = rc[INDEX_SIZE-1:0];

endmodule

// File: tb/tb_sparse_sa_scheduler.sv
// Directed bench for sparse_sa_scheduler: buffer model, skew/sentinel
// expectations per cycle, readout order, abort and async reset.
module tb_sparse_sa_scheduler;
    import sparse_sa_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy, done, cfg_err;
    logic [N*PTR_W-1:0]        a_nnz = '0;
    logic [N*PTR_W-1:0]        b_nnz = '0;
    logic [N*PTR_W-1:0]        a_rd_ptr, b_rd_ptr;
    logic [N*ELEM_W-1:0]       a_rd_data = '0;
    logic [N*ELEM_W-1:0]       b_rd_data = '0;
    logic [N*DATA_WIDTH-1:0]   arr_left, arr_up;
    logic [N*INDEX_SIZE-1:0]   arr_left_idx, arr_up_idx;
    logic [N*N*DATA_WIDTH-1:0] arr_result = '0;

    sparse_sa_scheduler_if res_if();

    int vectors = 0;
    int miscompares = 0;

    logic [ELEM_W-1:0] amem [N][16];
    logic [ELEM_W-1:0] bmem [N][16];
    int an [N];
    int bn [N];

    sparse_sa_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err),
        .a_nnz        (a_nnz),
        .b_nnz        (b_nnz),
        .a_rd_ptr     (a_rd_ptr),
        .b_rd_ptr     (b_rd_ptr),
        .a_rd_data    (a_rd_data),
        .b_rd_data    (b_rd_data),
        .arr_left     (arr_left),
        .arr_left_idx (arr_left_idx),
        .arr_up       (arr_up),
        .arr_up_idx   (arr_up_idx),
        .arr_result   (arr_result),
        .res          (res_if)
    );

    always #5 clk = ~clk;

    // External compressed buffers: one-cycle read latency.
    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            a_rd_data[k*ELEM_W +: ELEM_W] <= amem[k][a_rd_ptr[k*PTR_W +: PTR_W]];
            b_rd_data[k*ELEM_W +: ELEM_W] <= bmem[k][b_rd_ptr[k*PTR_W +: PTR_W]];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp_n(input int n);
        return (n > MAX_NNZ) ? MAX_NNZ : n;
    endfunction

    // Element on lane k's edge at cycle s after STREAM entry.
    function automatic logic [ELEM_W-1:0] lane_elem(input bit b, input int k, input int s);
        int n;
        int j;
        n = clamp_n(b ? bn[k] : an[k]);
        j = s - k - 1;
        if (j >= 0 && j < n) return b ? bmem[k][j] : amem[k][j];
        return '0;
    endfunction

    function automatic logic [63:0] exp_val(input bit b, input int s);
        logic [63:0] r;
        logic [ELEM_W-1:0] e;
        r = '0;
        for (int k = 0; k < N; k++) begin
            e = lane_elem(b, k, s);
            r[k*DATA_WIDTH +: DATA_WIDTH] = e[DATA_WIDTH-1:0];
        end
        return r;
    endfunction

    function automatic logic [63:0] exp_idx(input bit b, input int s);
        logic [63:0] r;
        logic [ELEM_W-1:0] e;
        r = '0;
        for (int k = 0; k < N; k++) begin
            e = lane_elem(b, k, s);
            r[k*INDEX_SIZE +: INDEX_SIZE] = e[ELEM_W-1:DATA_WIDTH];
        end
        return r;
    endfunction

    function automatic logic [63:0] exp_ptr(input bit b, input int s);
        logic [63:0] r;
        int n;
        r = '0;
        for (int k = 0; k < N; k++) begin
            n = clamp_n(b ? bn[k] : an[k]);
            if (s < T_STR && s - k >= 0 && s - k < n)
                r[k*PTR_W +: PTR_W] = PTR_W'(s - k);
        end
        return r;
    endfunction

    task automatic fill(input int seed);
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < 16; j++) begin
                amem[k][j] = {INDEX_SIZE'(j + k), DATA_WIDTH'(seed + k*16 + j*2 + 1)};
                bmem[k][j] = {INDEX_SIZE'(j*3 + k), DATA_WIDTH'(seed + k*8 + j*4 + 3)};
            end
        end
    endtask

    task automatic do_start();
        for (int k = 0; k < N; k++) begin
            a_nnz[k*PTR_W +: PTR_W] = PTR_W'(an[k]);
            b_nnz[k*PTR_W +: PTR_W] = PTR_W'(bn[k]);
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("load_busy", 64'(busy), 64'd1);
        @(negedge clk);
    endtask

    task automatic stream(input int first, input int last);
        for (int s = first; s <= last; s++) begin
            if (s != 0) @(negedge clk);
            chk($sformatf("left_s%0d", s), 64'(arr_left), exp_val(1'b0, s));
            chk($sformatf("left_idx_s%0d", s), 64'(arr_left_idx), exp_idx(1'b0, s));
            chk($sformatf("up_s%0d", s), 64'(arr_up), exp_val(1'b1, s));
            chk($sformatf("up_idx_s%0d", s), 64'(arr_up_idx), exp_idx(1'b1, s));
            chk($sformatf("a_ptr_s%0d", s), 64'(a_rd_ptr), exp_ptr(1'b0, s));
            chk($sformatf("b_ptr_s%0d", s), 64'(b_rd_ptr), exp_ptr(1'b1, s));
        end
    endtask

    task automatic readout(input bit bp, input bit hold_start);
        int i;
        int cyc;
        bit rdy;
        logic [7:0] ev;
        i = 0;
        cyc = 0;
        chk("drain_no_valid", 64'(res_if.res_valid), 64'd0);
        @(negedge clk);
        if (hold_start) start = 1'b1;
        while (i < N*N && cyc < 400) begin
            ev = 8'(i) ^ 8'hA5;
            chk("res_valid", 64'(res_if.res_valid), 64'd1);
            chk($sformatf("res_row_%0d", i), 64'(res_if.res_row), 64'(i / N));
            chk($sformatf("res_col_%0d", i), 64'(res_if.res_col), 64'(i % N));
            chk($sformatf("res_data_%0d", i), 64'(res_if.res_data), 64'(ev));
            chk("done_early", 64'(done), 64'd0);
            rdy = bp ? (cyc % 2 == 0) : 1'b1;
            res_if.res_ready = rdy;
            @(negedge clk);
            if (rdy) i++;
            cyc++;
        end
        start = 1'b0;
        res_if.res_ready = 1'b0;
        chk("readout_count", 64'(i), 64'(N*N));
        chk("done_pulse", 64'(done), 64'd1);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_valid", 64'(res_if.res_valid), 64'd0);
        @(negedge clk);
        chk("done_once", 64'(done), 64'd0);
        chk("stay_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        res_if.res_ready = 1'b0;
        for (int i = 0; i < N*N; i++)
            arr_result[i*DATA_WIDTH +: DATA_WIDTH] = 8'(i) ^ 8'hA5;
        fill(0);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_cfg_err", 64'(cfg_err), 64'd0);
        chk("rst_valid", 64'(res_if.res_valid), 64'd0);
        chk("rst_left", 64'(arr_left), 64'd0);
        chk("rst_up", 64'(arr_up), 64'd0);
        chk("rst_a_ptr", 64'(a_rd_ptr), 64'd0);
        chk("rst_b_ptr", 64'(b_rd_ptr), 64'd0);
        rst_n = 1'b1;

        // 1: dense identity, start held high while busy
        for (int k = 0; k < N; k++) begin
            an[k] = 8;
            bn[k] = 8;
            for (int j = 0; j < 16; j++) begin
                amem[k][j] = elem_pack(INDEX_SIZE'(j), 8'h10);
                bmem[k][j] = elem_pack(INDEX_SIZE'(j), 8'h10);
            end
        end
        do_start();
        start = 1'b1;
        stream(0, 31);
        start = 1'b0;
        chk("t1_cfg_err", 64'(cfg_err), 64'd0);
        readout(1'b0, 1'b0);

        // 2: empty A lane 2, one zero-valued element on A lane 5
        fill(2);
        an = '{8, 5, 0, 3, 8, 1, 7, 2};
        for (int k = 0; k < N; k++) bn[k] = 6;
        amem[5][0] = elem_pack(3'd5, 8'h00);
        do_start();
        chk("t2_cfg_err_load", 64'(cfg_err), 64'd0);
        stream(0, 31);
        chk("t2_cfg_err_zero", 64'(cfg_err), 64'd1);
        readout(1'b0, 1'b0);

        // 3: overflow on B column 0
        fill(4);
        for (int k = 0; k < N; k++) begin
            an[k] = 3;
            bn[k] = 5;
        end
        bn[0] = 9;
        do_start();
        chk("t3_cfg_err_load", 64'(cfg_err), 64'd1);
        stream(0, 31);
        readout(1'b0, 1'b0);
        chk("t3_cfg_err_sticky", 64'(cfg_err), 64'd1);

        // 4: backpressure on readout, start held during readout
        fill(6);
        for (int k = 0; k < N; k++) begin
            an[k] = k + 1;
            bn[k] = 8 - k;
        end
        do_start();
        chk("t4_cfg_err_clear", 64'(cfg_err), 64'd0);
        stream(0, 31);
        readout(1'b1, 1'b1);

        // 5: abort at t=5, then a clean pass
        fill(8);
        for (int k = 0; k < N; k++) begin
            an[k] = 8;
            bn[k] = 8;
        end
        do_start();
        stream(0, 5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_left", 64'(arr_left), 64'd0);
        chk("abort_left_idx", 64'(arr_left_idx), 64'd0);
        chk("abort_up", 64'(arr_up), 64'd0);
        chk("abort_up_idx", 64'(arr_up_idx), 64'd0);
        chk("abort_a_ptr", 64'(a_rd_ptr), 64'd0);
        chk("abort_b_ptr", 64'(b_rd_ptr), 64'd0);
        chk("abort_valid", 64'(res_if.res_valid), 64'd0);
        for (int c = 0; c < 3; c++) begin
            chk("abort_no_done", 64'(done), 64'd0);
            chk("abort_idle", 64'(busy), 64'd0);
            @(negedge clk);
        end
        fill(10);
        an = '{2, 7, 4, 8, 0, 6, 1, 5};
        bn = '{5, 0, 8, 3, 6, 2, 7, 1};
        do_start();
        stream(0, 31);
        readout(1'b0, 1'b0);

        // 6: async reset during READOUT
        fill(12);
        for (int k = 0; k < N; k++) begin
            an[k] = 2;
            bn[k] = 2;
        end
        bn[0] = 9;
        do_start();
        chk("t6_cfg_err_load", 64'(cfg_err), 64'd1);
        stream(0, 31);
        @(negedge clk);
        res_if.res_ready = 1'b0;
        chk("t6_in_readout", 64'(res_if.res_valid), 64'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(res_if.res_valid), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_cfg_err", 64'(cfg_err), 64'd0);
        chk("t6_rst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_post_busy", 64'(busy), 64'd0);
        chk("t6_post_valid", 64'(res_if.res_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
